// File: rtl/countdown_timer_if.sv
// Control pulses and display/status outputs of the BCD mm:ss countdown timer.
interface countdown_timer_if;
   logic       EN;
   logic       CLR;
   logic       START;
   logic       MINC;
   logic       SINC;
   logic [2:0] MH;
   logic [3:0] ML;
   logic [2:0] SH;
   logic [3:0] SL;
   logic       RUNNING;
   logic       ALARM;
   logic       DONE;

   modport master (
      output EN, CLR, START, MINC, SINC,
      input  MH, ML, SH, SL, RUNNING, ALARM, DONE
   );

   modport slave (
      input  EN, CLR, START, MINC, SINC,
      output MH, ML, SH, SL, RUNNING, ALARM, DONE
   );
endinterface

// File: rtl/countdown_timer.sv
// BCD minute:second countdown timer: load in IDLE, decrement on 1 Hz EN in RUN,
// pause/resume on START, and hold an ALARM for ALARM_LEN ticks after expiry.
module countdown_timer #(
   parameter int unsigned ALARM_LEN = 10
) (
   input logic              CLK,
   input logic              RST,
   countdown_timer_if.slave bus
);
   localparam int unsigned HW = 3;
   localparam int unsigned LW = 4;
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

   state_t        state;
   logic [HW-1:0] mh;
   logic [LW-1:0] ml;
   logic [HW-1:0] sh;
   logic [LW-1:0] sl;
   logic [CW-1:0] cnt;
   logic          running;
   logic          alarm;
   logic          done;
   logic          nonzero_c;
   logic          last_c;

   assign nonzero_c = (mh != '0) || (ml != '0) || (sh != '0) || (sl != '0);
   // 00:01 is the only value whose decrement lands on 00:00
   assign last_c    = (mh == '0) && (ml == '0) && (sh == '0) && (sl == LW'(1));

   always_ff @(posedge CLK) begin
      done <= 1'b0;
      if (RST || bus.CLR) begin
         state   <= ST_IDLE;
         mh      <= '0;
         ml      <= '0;
         sh      <= '0;
         sl      <= '0;
         cnt     <= '0;
         running <= 1'b0;
         alarm   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.START && nonzero_c) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end else begin
                  if (bus.MINC) begin
                     if (ml == LW'(9)) begin
                        ml <= '0;
                        mh <= (mh == HW'(5)) ? '0 : mh + HW'(1);
                     end else begin
                        ml <= ml + LW'(1);
                     end
                  end
                  if (bus.SINC) begin
                     if (sl == LW'(9)) begin
                        sl <= '0;
                        sh <= (sh == HW'(5)) ? '0 : sh + HW'(1);
                     end else begin
                        sl <= sl + LW'(1);
                     end
                  end
               end
            end
            ST_RUN: begin
               if (bus.START) begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end else if (bus.EN) begin
                  // Borrow chain SL -> SH -> ML -> MH; never reached at 00:00
                  if (sl != '0) begin
                     sl <= sl - LW'(1);
                  end else begin
                     sl <= LW'(9);
                     if (sh != '0) begin
                        sh <= sh - HW'(1);
                     end else begin
                        sh <= HW'(5);
                        if (ml != '0) begin
                           ml <= ml - LW'(1);
                        end else begin
                           ml <= LW'(9);
                           mh <= mh - HW'(1);
                        end
                     end
                  end
                  if (last_c) begin
                     state   <= ST_ALARM;
                     running <= 1'b0;
                     alarm   <= 1'b1;
                     done    <= 1'b1;
                  end
               end
            end
            ST_PAUSE: begin
               if (bus.START) begin
                  state   <= ST_RUN;
                  running <= 1'b1;
               end
            end
            ST_ALARM: begin
               if (bus.START) begin
                  state <= ST_IDLE;
                  alarm <= 1'b0;
                  cnt   <= '0;
               end else if (bus.EN) begin
                  if (cnt == CW'(ALARM_LEN - 1)) begin
                     state <= ST_IDLE;
                     alarm <= 1'b0;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            default: begin
               state   <= ST_IDLE;
               running <= 1'b0;
               alarm   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.MH      = mh;
   assign bus.ML      = ml;
   assign bus.SH      = sh;
   assign bus.SL      = sl;
   assign bus.RUNNING = running;
   assign bus.ALARM   = alarm;
   assign bus.DONE    = done;
endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: a seconds-arithmetic model checked every cycle,
// directed scenarios pinned with literal readings, then randomized pulses.
module tb_countdown_timer;
   localparam int AL = 10;

   logic CLK;
   logic RST;
   countdown_timer_if bus();

   countdown_timer #(.ALARM_LEN(AL)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_ALARM = 3;

   int m_min, m_sec, m_mode, m_cnt, m_done;
   int total = 0;
   int bad   = 0;

   // Model: time kept as plain minutes/seconds, expiry via total-seconds math
   task automatic model_step(input int rst, input int clr, input int start,
                             input int minc, input int sinc, input int en);
      int t;
      m_done = 0;
      if (rst != 0 || clr != 0) begin
         m_min = 0; m_sec = 0; m_mode = M_IDLE; m_cnt = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (start != 0 && (m_min != 0 || m_sec != 0)) m_mode = M_RUN;
               else begin
                  if (minc != 0) m_min = (m_min + 1) % 60;
                  if (sinc != 0) m_sec = (m_sec + 1) % 60;
               end
            end
            M_RUN: begin
               if (start != 0) m_mode = M_PAUSE;
               else if (en != 0) begin
                  t = m_min * 60 + m_sec - 1;
                  m_min = t / 60;
                  m_sec = t % 60;
                  if (t == 0) begin m_mode = M_ALARM; m_done = 1; end
               end
            end
            M_PAUSE: if (start != 0) m_mode = M_RUN;
            default: begin
               if (start != 0) begin m_mode = M_IDLE; m_cnt = 0; end
               else if (en != 0) begin
                  m_cnt = m_cnt + 1;
                  if (m_cnt == AL) begin m_mode = M_IDLE; m_cnt = 0; end
               end
            end
         endcase
      end
   endtask

   function automatic int dut_dig();
      return int'(bus.MH) * 1000 + int'(bus.ML) * 100 + int'(bus.SH) * 10 + int'(bus.SL);
   endfunction

   task automatic compare_model();
      int exp_dig, act_st, exp_st;
      exp_dig = (m_min / 10) * 1000 + (m_min % 10) * 100 + (m_sec / 10) * 10 + (m_sec % 10);
      exp_st  = ((m_mode == M_RUN) ? 4 : 0) + ((m_mode == M_ALARM) ? 2 : 0) + m_done;
      act_st  = int'(bus.RUNNING) * 4 + int'(bus.ALARM) * 2 + int'(bus.DONE);
      total++;
      if (exp_dig != dut_dig() || exp_st != act_st) begin
         bad++;
         $display("FAIL model t=%0t digits got=%0d want=%0d run/alarm/done got=%0b want=%0b",
                  $time, dut_dig(), exp_dig, act_st[2:0], exp_st[2:0]);
      end
   endtask

   task automatic lit(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, advance, compare at the next falling edge
   task automatic cyc(input int rst, input int clr, input int start,
                      input int minc, input int sinc, input int en);
      RST       = (rst != 0);
      bus.CLR   = (clr != 0);
      bus.START = (start != 0);
      bus.MINC  = (minc != 0);
      bus.SINC  = (sinc != 0);
      bus.EN    = (en != 0);
      model_step(rst, clr, start, minc, sinc, en);
      @(posedge CLK);
      @(negedge CLK);
      compare_model();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   task automatic load(input int mins, input int secs);
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < mins; i++) cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < secs; i++) cyc(0, 0, 0, 0, 1, 0);
   endtask

   initial begin
      int r, st, mi, si, en, cl, rs;
      RST = 1'b1; bus.CLR = 1'b0; bus.START = 1'b0;
      bus.MINC = 1'b0; bus.SINC = 1'b0; bus.EN = 1'b0;
      m_min = 0; m_sec = 0; m_mode = M_IDLE; m_cnt = 0; m_done = 0;

      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);
      lit("reset_digits", dut_dig(), 0);
      lit("reset_flags", int'(bus.RUNNING) + int'(bus.ALARM) + int'(bus.DONE), 0);

      // Reset and load
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 0);
      lit("load_0302", dut_dig(), 302);
      lit("load_running", int'(bus.RUNNING), 0);

      // Borrow chain
      load(10, 0);
      cyc(0, 0, 1, 0, 0, 0);
      lit("start_running", int'(bus.RUNNING), 1);
      cyc(0, 0, 0, 0, 0, 1);
      lit("borrow_0959", dut_dig(), 959);
      load(1, 0);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      lit("borrow_0059", dut_dig(), 59);

      // Expiry and alarm length
      load(0, 2);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      lit("expiry_no_done_early", int'(bus.DONE), 0);
      cyc(0, 0, 0, 0, 0, 1);
      lit("expiry_digits", dut_dig(), 0);
      lit("expiry_done", int'(bus.DONE), 1);
      lit("expiry_alarm", int'(bus.ALARM), 1);
      lit("expiry_running", int'(bus.RUNNING), 0);
      cyc(0, 0, 0, 0, 0, 0);
      lit("done_one_cycle", int'(bus.DONE), 0);
      for (int i = 0; i < AL - 1; i++) cyc(0, 0, 0, 0, 0, 1);
      lit("alarm_before_last", int'(bus.ALARM), 1);
      cyc(0, 0, 0, 0, 0, 1);
      lit("alarm_after_len", int'(bus.ALARM), 0);
      cyc(0, 0, 0, 1, 0, 0);
      lit("idle_after_alarm", dut_dig(), 100);

      // Pause with coincident EN dropped
      load(0, 30);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0, 1);
      lit("pause_hold", dut_dig(), 30);
      lit("pause_running", int'(bus.RUNNING), 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 1);
      lit("pause_ignore", dut_dig(), 30);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      lit("resume_0029", dut_dig(), 29);

      // Wrap without carry, START at zero ignored
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 1, 0);
      lit("load_5959", dut_dig(), 5959);
      cyc(0, 0, 0, 1, 1, 0);
      lit("wrap_0000", dut_dig(), 0);
      cyc(0, 0, 1, 0, 0, 0);
      lit("start_zero_ignored", int'(bus.RUNNING), 0);
      cyc(0, 0, 0, 0, 1, 0);
      lit("sinc_no_carry", dut_dig(), 1);

      // Clear during RUN, silence during ALARM
      load(5, 17);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 1);
      lit("clr_digits", dut_dig(), 0);
      lit("clr_flags", int'(bus.RUNNING) + int'(bus.ALARM) + int'(bus.DONE), 0);
      load(0, 1);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1);
      lit("silence_pre_alarm", int'(bus.ALARM), 1);
      cyc(0, 0, 1, 0, 0, 1);
      lit("silence_alarm", int'(bus.ALARM), 0);

      // Randomized pulses; START never coincides with MINC/SINC
      for (int i = 0; i < 6000; i++) begin
         r  = int'($urandom_range(0, 99));
         rs = (r == 0) ? 1 : 0;
         cl = (int'($urandom_range(0, 199)) == 0) ? 1 : 0;
         st = (int'($urandom_range(0, 29)) == 0) ? 1 : 0;
         mi = (st == 0 && int'($urandom_range(0, 39)) == 0) ? 1 : 0;
         si = (st == 0 && int'($urandom_range(0, 4)) == 0) ? 1 : 0;
         en = int'($urandom_range(0, 1));
         cyc(rs, cl, st, mi, si, en);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/countdown_timer.md
# countdown_timer

Two-stage BCD minute:second countdown timer (00:00–59:59). It runs the other direction from the up-counting 60-stage time counters: the user loads a duration, starts it, and the block decrements once per 1 Hz tick and raises an alarm when it reaches 00:00. It sits beside the clock counters, shares their `EN` tick and display digit format, and feeds the display mux and alarm driver.

## Interface
- `ALARM_LEN`, default 10: number of `EN` ticks `ALARM` stays high after expiry. Legal range 1–255.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `EN`  in  1  one-cycle 1 Hz tick pulse.
- `CLR`  in  1  synchronous clear: digits to 00:00, state to IDLE.
- `START`  in  1  one-cycle pulse; start, pause or resume, or silence the alarm.
- `MINC`  in  1  one-cycle pulse; minutes +1 (IDLE only).
- `SINC`  in  1  one-cycle pulse; seconds +1 (IDLE only).
- `MH`  out  3  minutes tens, BCD 0–5.
- `ML`  out  4  minutes units, BCD 0–9.
- `SH`  out  3  seconds tens, BCD 0–5.
- `SL`  out  4  seconds units, BCD 0–9.
- `RUNNING`  out  1  high in RUN.
- `ALARM`  out  1  high in ALARM.
- `DONE`  out  1  one-cycle pulse on expiry.

## Operation
- **States:** IDLE, RUN, PAUSE, ALARM. All outputs are registered.
- **Reset:** IDLE; all digits 0; `RUNNING`, `ALARM` and `DONE` are 0; alarm tick counter is 0.
- **Priority per cycle:** `RST` > `CLR` > `START` > `MINC`/`SINC` > `EN`.
- **`CLR` in any state:** go to IDLE, zero all digits, clear the alarm counter.
- **IDLE:**
  - `MINC` increments minutes as a BCD mod-60 count (ML 9→0 carries to MH; 59→00 wraps). No effect on seconds.
  - `SINC` does the same for seconds. It never carries into minutes.
  - `MINC` and `SINC` in the same cycle both apply.
  - `START` with a nonzero value goes to RUN. `START` at 00:00 is ignored.
  - `EN` is ignored.
- **RUN:** on `EN`, decrement the value by one second.
  - SL 0→9 borrows from SH.
  - SH 0→5 borrows from minutes.
  - ML 0→9 borrows from MH.
  - No underflow is possible, because RUN is never entered at 00:00.
- **Expiry:** if the `EN` decrement produces 00:00, the next state is ALARM. `DONE` is high for exactly the cycle after that edge, coincident with the digits first showing 00:00.
- **`START` in RUN:** go to PAUSE. An `EN` in the same cycle is dropped and the digits are unchanged.
- **PAUSE:** digits are held; `EN`, `MINC` and `SINC` are ignored. `START` returns to RUN; a coincident `EN` is dropped.
- **ALARM:**
  - The counter increments on each `EN`. When it reaches `ALARM_LEN`, go to IDLE and clear the counter.
  - `START` silences immediately: go to IDLE and clear the counter.
  - Digits stay 00:00; `MINC` and `SINC` are ignored.
- **Digit validity:** digits never leave their BCD ranges, including at wrap and borrow boundaries.

## Timing
- Every input is sampled at the rising edge of `CLK`. The response is visible after that same edge, so input-to-output latency is 1 cycle.
- The digit update and any state change happen on the same edge as the `EN` that causes them.
- `RUNNING` rises on the edge that samples `START` in IDLE or PAUSE, and falls on the edge that enters PAUSE, ALARM or IDLE.
- `ALARM` rises together with `DONE`. With uninterrupted ticks it falls on the edge of the `ALARM_LEN`-th `EN` after entry.
- `DONE` never lasts more than 1 cycle, and never asserts without entry to ALARM.
- `RST` or `CLR` mid-run or mid-alarm takes effect on the next edge with no `DONE` pulse.
- Inputs are assumed to be single-cycle, already synchronized pulses. Held levels act as repeated pulses.

## Test plan
- **Reset and load:** reset, then 3×`MINC` and 2×`SINC` -> reads 03:02 (MH=0, ML=3, SH=0, SL=2), `RUNNING`=0.
- **Borrow chain:** load 10:00, `START`, 1 `EN` -> 09:59. Load 01:00, 1 `EN` -> 00:59.
- **Expiry:** load 00:02, `START`, 2 `EN` -> 00:00, `DONE` high for 1 cycle, `ALARM`=1. 10 more `EN` (`ALARM_LEN`=10) -> `ALARM`=0, IDLE.
- **Pause:** RUN at 00:30, then `START` with a coincident `EN` -> PAUSE at 00:30. 5 `EN` -> still 00:30. `START`, 1 `EN` -> 00:29.
- **Wrap and ignore:** IDLE at 59:59; `MINC`+`SINC` together -> 00:00 with no carry. `START` at 00:00 -> stays IDLE.
- **Clear and silence:** `CLR` during RUN at 05:17 -> 00:00, IDLE, no `DONE`. `START` during ALARM -> `ALARM`=0 on the next edge.
